// File: rtl/gate_pattern_checker.sv
// gate_pattern_checker: clocked stimulus/response checker for a two-input
// NAND (t0) / NOR (t1) gate. Steps {a,b} through 00,01,10,11, holding each
// vector HOLD_CYCLES cycles, samples the gate outputs at the end of every
// hold window and reports a mismatch mask, a mismatch count and pass/done.
module gate_pattern_checker #(
    parameter int unsigned HOLD_CYCLES = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       t0,
    input  logic       t1,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_mask,
    output logic [2:0] err_count
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        vec;
    logic [HOLD_W-1:0] hold;
    logic [1:0]        vec_next_c;
    logic              hold_end_c;
    logic              mismatch_c;

    // End of the current hold window and the vector that follows it
    assign hold_end_c = (hold == HOLD_LAST);
    assign vec_next_c = vec + 2'd1;

    // Gate response against the truth table for the vector currently on a/b
    assign mismatch_c = (t0 != ~(a & b)) || (t1 != ~(a | b));

    // Sequencer: drive vectors, sample at end of each hold, report results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            vec       <= 2'd0;
            hold      <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_mask  <= 4'b0000;
            err_count <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // start wins over a simultaneous abort; abort is ignored here
                    if (start) begin
                        state     <= ST_DRIVE;
                        vec       <= 2'd0;
                        hold      <= '0;
                        a         <= 1'b0;
                        b         <= 1'b0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        err_mask  <= 4'b0000;
                        err_count <= 3'd0;
                    end
                end

                ST_DRIVE: begin
                    if (abort) begin
                        // Partial error results are kept; pass stays low
                        state <= ST_IDLE;
                        vec   <= 2'd0;
                        hold  <= '0;
                        a     <= 1'b0;
                        b     <= 1'b0;
                        busy  <= 1'b0;
                    end else if (hold_end_c) begin
                        // One count per failing vector, even if both outputs are wrong
                        if (mismatch_c) begin
                            err_mask[vec] <= 1'b1;
                            err_count     <= err_count + 3'd1;
                        end
                        hold <= '0;
                        if (vec == 2'd3) begin
                            state <= ST_DONE;
                            vec   <= 2'd0;
                            a     <= 1'b0;
                            b     <= 1'b0;
                        end else begin
                            vec <= vec_next_c;
                            a   <= vec_next_c[1];
                            b   <= vec_next_c[0];
                        end
                    end else begin
                        hold <= hold + HOLD_W'(1);
                    end
                end

                ST_DONE: begin
                    // err_count already holds the vector-3 result here
                    state <= ST_IDLE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (err_count == 3'd0);
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_pattern_checker.sv
// Bench for gate_pattern_checker: two instances (H=20 and H=4) check behavioural
// gate models with selectable faults. Expected run results are queued when a
// run is started and popped by per-instance monitors on every done pulse.
module tb_gate_pattern_checker;

    typedef struct {
        logic [3:0] mask;
        logic [2:0] cnt;
        logic       pass;
        int         start_cyc;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    logic       start20 = 1'b0, abort20 = 1'b0;
    logic       t0_20, t1_20, a20, b20, busy20, done20, pass20;
    logic [3:0] mask20;
    logic [2:0] cnt20;
    logic [1:0] f20 = 2'd0;

    logic       start4 = 1'b0, abort4 = 1'b0;
    logic       t0_4, t1_4, a4, b4, busy4, done4, pass4;
    logic [3:0] mask4;
    logic [2:0] cnt4;
    logic [1:0] f4 = 2'd0;

    exp_t q20[$];
    exp_t q4[$];
    exp_t e20, e4;
    int   n_total = 0;
    int   n_pass = 0;
    int   done_seen20 = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate model: 0 good, 1 t0 stuck at 1, 2 t0/t1 swapped, 3 t1 stuck at 0
    function automatic logic [1:0] gate(input logic [1:0] mode, input logic ga, input logic gb);
        logic nand_v, nor_v;
        nand_v = ~(ga & gb);
        nor_v  = ~(ga | gb);
        case (mode)
            2'd0: gate = {nor_v, nand_v};
            2'd1: gate = {nor_v, 1'b1};
            2'd2: gate = {nand_v, nor_v};
            default: gate = {1'b0, nand_v};
        endcase
    endfunction

    assign {t1_20, t0_20} = gate(f20, a20, b20);
    assign {t1_4, t0_4}   = gate(f4, a4, b4);

    gate_pattern_checker #(.HOLD_CYCLES(20)) u20 (
        .clk(clk), .rst_n(rst_n), .start(start20), .abort(abort20),
        .t0(t0_20), .t1(t1_20), .a(a20), .b(b20), .busy(busy20),
        .done(done20), .pass(pass20), .err_mask(mask20), .err_count(cnt20)
    );

    gate_pattern_checker #(.HOLD_CYCLES(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
        .t0(t0_4), .t1(t1_4), .a(a4), .b(b4), .busy(busy4),
        .done(done4), .pass(pass4), .err_mask(mask4), .err_count(cnt4)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse start (optionally with abort) for one edge; sc = start edge index
    task automatic start_run(input bit on4, input bit with_abort, output int sc);
        @(negedge clk);
        if (on4) begin start4 = 1'b1; abort4 = with_abort; end
        else begin start20 = 1'b1; abort20 = with_abort; end
        @(negedge clk);
        sc = cyc;
        start4 = 1'b0; abort4 = 1'b0; start20 = 1'b0; abort20 = 1'b0;
    endtask

    task automatic push_exp(input bit on4, input logic [3:0] m, input logic [2:0] c,
                            input logic p, input int sc, input int lat);
        exp_t e;
        e.mask = m; e.cnt = c; e.pass = p; e.start_cyc = sc; e.lat = lat;
        if (on4) q4.push_back(e);
        else q20.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && (q20.size() + q4.size()) != 0; i++) tick(1);
        chk("queue_drained", q20.size() + q4.size(), 0);
    endtask

    task automatic chk_reset20(input string tag);
        chk({tag, "_a"}, a20, 0);
        chk({tag, "_b"}, b20, 0);
        chk({tag, "_busy"}, busy20, 0);
        chk({tag, "_done"}, done20, 0);
        chk({tag, "_pass"}, pass20, 0);
        chk({tag, "_mask"}, mask20, 0);
        chk({tag, "_count"}, cnt20, 0);
    endtask

    // Monitor, H=20 instance
    always @(negedge clk) begin
        if (mon_en && rst_n && done20) begin
            done_seen20++;
            chk("done20_expected", int'(q20.size() != 0), 1);
            if (q20.size() != 0) begin
                e20 = q20.pop_front();
                chk("mask20", mask20, e20.mask);
                chk("count20", cnt20, e20.cnt);
                chk("pass20", pass20, e20.pass);
                chk("latency20", cyc - e20.start_cyc, e20.lat);
                chk("busy20_at_done", busy20, 0);
            end
        end
    end

    // Monitor, H=4 instance
    always @(negedge clk) begin
        if (mon_en && rst_n && done4) begin
            chk("done4_expected", int'(q4.size() != 0), 1);
            if (q4.size() != 0) begin
                e4 = q4.pop_front();
                chk("mask4", mask4, e4.mask);
                chk("count4", cnt4, e4.cnt);
                chk("pass4", pass4, e4.pass);
                chk("latency4", cyc - e4.start_cyc, e4.lat);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int sc, k0, ds;

        // Reset state
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        chk_reset20("reset20");
        chk("reset4_busy", busy4, 0);
        chk("reset4_mask", mask4, 0);
        mon_en = 1'b1;

        // H=4, t0 stuck at 1: only vector 3 (NAND=0) fails
        f4 = 2'd1;
        start_run(1'b1, 1'b0, sc);
        push_exp(1'b1, 4'b1000, 3'd1, 1'b0, sc, 17);
        wait_drain(100);

        // H=4, good gate, start and abort together in IDLE: start wins
        f4 = 2'd0;
        start_run(1'b1, 1'b1, sc);
        chk("start_beats_abort_busy", busy4, 1);
        push_exp(1'b1, 4'b0000, 3'd0, 1'b1, sc, 17);
        wait_drain(100);

        // H=20, good gate, vector stepping, re-pulsed start at cycle 10 ignored
        f20 = 2'd0;
        start_run(1'b0, 1'b0, sc);
        push_exp(1'b0, 4'b0000, 3'd0, 1'b1, sc, 81);
        tick(1);
        chk("vec0_ab", {a20, b20}, 0);
        chk("vec0_busy", busy20, 1);
        tick(8);
        start20 = 1'b1;
        tick(1);
        start20 = 1'b0;
        tick(11);
        chk("vec1_ab", {a20, b20}, 1);
        tick(20);
        chk("vec2_ab", {a20, b20}, 2);
        tick(20);
        chk("vec3_ab", {a20, b20}, 3);
        wait_drain(100);
        tick(5);
        chk("pass_held", pass20, 1);
        chk("idle_ab", {a20, b20}, 0);

        // H=20, t0/t1 swapped: vectors 01 and 10 fail
        f20 = 2'd2;
        start_run(1'b0, 1'b0, sc);
        push_exp(1'b0, 4'b0110, 3'd2, 1'b0, sc, 81);
        wait_drain(200);

        // H=20, start held 200 cycles: back-to-back runs every 82 cycles
        f20 = 2'd0;
        @(negedge clk);
        start20 = 1'b1;
        tick(1);
        k0 = cyc;
        push_exp(1'b0, 4'b0000, 3'd0, 1'b1, k0, 81);
        push_exp(1'b0, 4'b0000, 3'd0, 1'b1, k0 + 82, 81);
        push_exp(1'b0, 4'b0000, 3'd0, 1'b1, k0 + 164, 81);
        tick(81);
        chk("held_pass_after_run1", pass20, 1);
        tick(1);
        chk("held_pass_cleared", pass20, 0);
        chk("held_rerun_busy", busy20, 1);
        tick(117);
        start20 = 1'b0;
        wait_drain(200);
        tick(5);
        chk("held_no_extra_run", busy20, 0);

        // H=20, t1 stuck at 0, abort at cycle 30 (vector 1)
        f20 = 2'd3;
        start_run(1'b0, 1'b0, sc);
        tick(29);
        abort20 = 1'b1;
        tick(1);
        abort20 = 1'b0;
        chk("abort_busy", busy20, 0);
        chk("abort_ab", {a20, b20}, 0);
        chk("abort_mask", mask20, 1);
        chk("abort_count", cnt20, 1);
        chk("abort_pass", pass20, 0);
        ds = done_seen20;
        tick(100);
        chk("abort_no_done", done_seen20 - ds, 0);

        // H=20, reset mid-vector-2, then a clean run
        start_run(1'b0, 1'b0, sc);
        tick(44);
        chk("pre_reset_mask", mask20, 1);
        chk("pre_reset_ab", {a20, b20}, 2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk_reset20("midrun_reset");
        ds = done_seen20;
        tick(60);
        chk("reset_no_done", done_seen20 - ds, 0);
        f20 = 2'd0;
        start_run(1'b0, 1'b0, sc);
        push_exp(1'b0, 4'b0000, 3'd0, 1'b1, sc, 81);
        wait_drain(200);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
